// File: rtl/pwm_decoder_if.sv
// rtl/pwm_decoder_if.sv - PWM decoder signal bundle: PWM input and decoded duty results
interface pwm_decoder_if;
    logic       pwm_in;
    logic [3:0] duty;
    logic       duty_valid;
    logic       period_err;
    logic       locked;

    modport master (
        output pwm_in,
        input  duty,
        input  duty_valid,
        input  period_err,
        input  locked
    );

    modport slave (
        input  pwm_in,
        output duty,
        output duty_valid,
        output period_err,
        output locked
    );
endinterface

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - PWM duty decoder: synchronizes pwm_in, measures period/high time, reports duty in 10 % steps
module pwm_decoder #(
    parameter int PERIOD_CYCLES = 10,
    parameter int PERIOD_TOL    = 1,
    parameter int TIMEOUT       = 30,
    parameter int SYNC_STAGES   = 2
) (
    input  logic         clk,
    input  logic         reset,
    pwm_decoder_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] P_MIN   = CW'(PERIOD_CYCLES - PERIOD_TOL);
    localparam logic [CW-1:0] P_MAX   = CW'(PERIOD_CYCLES + PERIOD_TOL);
    localparam logic [CW-1:0] T_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise, fall;
    logic [CW-1:0]          cnt, h_cnt, h_next;
    logic                   timeout, in_tol, go_stuck;
    int                     duty_int;
    logic [3:0]             duty_calc;

    logic [3:0] duty_r, duty_next;
    logic       dv_r, dv_next;
    logic       pe_r, pe_next;
    logic       lock_r, lock_next;

    assign s = sync[SYNC_STAGES-1];

    // Edge strobes are registered so downstream logic sees clean one-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            s_d  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.pwm_in};
            s_d  <= s;
            rise <= s & ~s_d;
            fall <= ~s & s_d;
        end
    end

    // cnt holds the number of cycles since the last rise strobe, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CW'(1);
        end else if (!timeout) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout  = (cnt == T_LIMIT);
    assign in_tol   = (cnt >= P_MIN) && (cnt <= P_MAX);
    assign duty_int = (32'(h_cnt) * 10 + PERIOD_CYCLES / 2) / PERIOD_CYCLES;
    assign duty_calc = (duty_int > 10) ? 4'd10 : duty_int[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        h_next     = h_cnt;
        duty_next  = duty_r;
        dv_next    = 1'b0;
        pe_next    = 1'b0;
        lock_next  = lock_r;
        go_stuck   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HIGH;
                end else if (timeout) begin
                    go_stuck = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    h_next     = cnt;
                    state_next = LOW;
                end else if (timeout) begin
                    go_stuck = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_next = HIGH;
                    if (in_tol) begin
                        duty_next = duty_calc;
                        dv_next   = 1'b1;
                        lock_next = 1'b1;
                    end else begin
                        pe_next   = 1'b1;
                        lock_next = 1'b0;
                    end
                end else if (timeout) begin
                    go_stuck = 1'b1;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_next = HIGH;
                end
            end
            default: state_next = IDLE;
        endcase
        // A stuck line reports the level it is stuck at, once, on entry.
        if (go_stuck) begin
            state_next = STUCK;
            duty_next  = s ? 4'd10 : 4'd0;
            dv_next    = 1'b1;
            lock_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt  <= '0;
            duty_r <= 4'd0;
            dv_r   <= 1'b0;
            pe_r   <= 1'b0;
            lock_r <= 1'b0;
        end else begin
            h_cnt  <= h_next;
            duty_r <= duty_next;
            dv_r   <= dv_next;
            pe_r   <= pe_next;
            lock_r <= lock_next;
        end
    end

    assign bus.duty       = duty_r;
    assign bus.duty_valid = dv_r;
    assign bus.period_err = pe_r;
    assign bus.locked     = lock_r;
endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - directed self-checking bench for pwm_decoder
module tb_pwm_decoder;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   cyc;
    int   dq[$];
    int   pe_total;
    int   both_cnt;
    int   wide_cnt;
    int   viol;
    int   dv_cyc;
    logic prev_dv;

    pwm_decoder_if bus();

    pwm_decoder #(
        .PERIOD_CYCLES(10),
        .PERIOD_TOL   (1),
        .TIMEOUT      (30),
        .SYNC_STAGES  (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.duty_valid) begin
            dq.push_back(int'(bus.duty));
            dv_cyc = cyc;
        end
        if (bus.period_err) pe_total++;
        if (bus.duty_valid && bus.period_err) both_cnt++;
        if (bus.duty_valid && prev_dv) wide_cnt++;
        prev_dv = bus.duty_valid;
        if (!reset && (bus.duty != 4'd0 || bus.duty_valid || bus.period_err || bus.locked)) viol++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_period(input int high, input int period);
        for (int i = 0; i < period; i++) begin
            @(negedge clk);
            bus.pwm_in = (i < high);
        end
    endtask

    task automatic hold_level(input logic lvl, input int n);
        @(negedge clk);
        bus.pwm_in = lvl;
        wait_cycles(n - 1);
    endtask

    task automatic test_reset;
        int base;
        reset = 1'b0;
        bus.pwm_in = 1'b0;
        for (int k = 0; k < 3; k++) drive_period(5, 10);
        #1;
        checks++; if (bus.duty !== 4'd0)    begin errors++; $display("FAIL reset_duty: got %0d want 0", bus.duty); end
        checks++; if (bus.duty_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", bus.duty_valid); end
        checks++; if (bus.period_err !== 1'b0) begin errors++; $display("FAIL reset_pe: got %b want 0", bus.period_err); end
        checks++; if (bus.locked !== 1'b0)  begin errors++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL reset_hold: %0d active-output samples during reset, want 0", viol); end
        @(negedge clk);
        bus.pwm_in = 1'b0;
        reset = 1'b1;
        base = dq.size();
        drive_period(3, 10);
        drive_period(3, 3);
        checks++; if (dq.size() - base !== 0) begin errors++; $display("FAIL first_rise_no_dv: got %0d pulses want 0", dq.size() - base); end
        hold_level(1'b0, 7);
        checks++; if (dq.size() - base !== 1) begin errors++; $display("FAIL first_period_dv: got %0d pulses want 1", dq.size() - base); end
        checks++; if (bus.duty !== 4'd3) begin errors++; $display("FAIL first_period_duty: got %0d want 3", bus.duty); end
    endtask

    task automatic test_duty(input int high, input int exp);
        int base, pbase;
        base  = dq.size();
        pbase = pe_total;
        for (int k = 0; k < 5; k++) drive_period(high, 10);
        checks++; if (dq.size() - base !== 5) begin errors++; $display("FAIL duty%0d_count: got %0d pulses want 5", exp, dq.size() - base); end
        checks++; if (dq[dq.size()-1] !== exp) begin errors++; $display("FAIL duty%0d_value: got %0d want %0d", exp, dq[dq.size()-1], exp); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL duty%0d_locked: got %b want 1", exp, bus.locked); end
        checks++; if (pe_total - pbase !== 0) begin errors++; $display("FAIL duty%0d_pe: got %0d errors want 0", exp, pe_total - pbase); end
    endtask

    task automatic test_switch;
        int base, pbase;
        for (int k = 0; k < 3; k++) drive_period(3, 10);
        base  = dq.size();
        pbase = pe_total;
        for (int k = 0; k < 3; k++) drive_period(7, 10);
        checks++; if (dq.size() - base !== 3) begin errors++; $display("FAIL switch_count: got %0d want 3", dq.size() - base); end
        checks++; if (dq[base] !== 3)   begin errors++; $display("FAIL switch_old: got %0d want 3", dq[base]); end
        checks++; if (dq[base+1] !== 7) begin errors++; $display("FAIL switch_first_new: got %0d want 7", dq[base+1]); end
        checks++; if (dq[base+2] !== 7) begin errors++; $display("FAIL switch_second_new: got %0d want 7", dq[base+2]); end
        checks++; if (pe_total - pbase !== 0) begin errors++; $display("FAIL switch_pe: got %0d want 0", pe_total - pbase); end
    endtask

    task automatic test_stuck;
        int base, rel;
        @(negedge clk);
        reset = 1'b0;
        bus.pwm_in = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        rel  = cyc;
        base = dq.size();
        wait_cycles(40);
        checks++; if (dq.size() - base !== 1) begin errors++; $display("FAIL stuck_low_count: got %0d want 1", dq.size() - base); end
        checks++; if (bus.duty !== 4'd0) begin errors++; $display("FAIL stuck_low_duty: got %0d want 0", bus.duty); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL stuck_low_locked: got %b want 0", bus.locked); end
        checks++; if (dv_cyc - rel < 30 || dv_cyc - rel > 32) begin errors++; $display("FAIL stuck_low_time: got %0d cycles want 30..32", dv_cyc - rel); end
        base = dq.size();
        hold_level(1'b1, 45);
        checks++; if (dq.size() - base !== 1) begin errors++; $display("FAIL stuck_high_count: got %0d want 1", dq.size() - base); end
        checks++; if (bus.duty !== 4'd10) begin errors++; $display("FAIL stuck_high_duty: got %0d want 10", bus.duty); end
        hold_level(1'b0, 5);
        base = dq.size();
        for (int k = 0; k < 4; k++) drive_period(5, 10);
        checks++; if (dq.size() - base !== 3) begin errors++; $display("FAIL relock_count: got %0d want 3", dq.size() - base); end
        checks++; if (bus.duty !== 4'd5) begin errors++; $display("FAIL relock_duty: got %0d want 5", bus.duty); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL relock_locked: got %b want 1", bus.locked); end
        base = dq.size();
        hold_level(1'b0, 40);
        checks++; if (dq.size() - base !== 1) begin errors++; $display("FAIL unlock_count: got %0d want 1", dq.size() - base); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL unlock_locked: got %b want 0", bus.locked); end
        checks++; if (bus.duty !== 4'd0) begin errors++; $display("FAIL unlock_duty: got %0d want 0", bus.duty); end
    endtask

    task automatic test_period_err;
        int base, pbase;
        for (int k = 0; k < 3; k++) drive_period(3, 10);
        base  = dq.size();
        pbase = pe_total;
        for (int k = 0; k < 4; k++) drive_period(5, 14);
        checks++; if (pe_total - pbase !== 3) begin errors++; $display("FAIL p14_pe: got %0d want 3", pe_total - pbase); end
        checks++; if (dq.size() - base !== 1) begin errors++; $display("FAIL p14_dv: got %0d want 1", dq.size() - base); end
        checks++; if (bus.duty !== 4'd3) begin errors++; $display("FAIL p14_duty_hold: got %0d want 3", bus.duty); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL p14_locked: got %b want 0", bus.locked); end
        base  = dq.size();
        pbase = pe_total;
        for (int k = 0; k < 3; k++) drive_period(5, 11);
        checks++; if (pe_total - pbase !== 1) begin errors++; $display("FAIL p11_pe: got %0d want 1", pe_total - pbase); end
        checks++; if (dq.size() - base !== 2) begin errors++; $display("FAIL p11_dv: got %0d want 2", dq.size() - base); end
        checks++; if (bus.duty !== 4'd5) begin errors++; $display("FAIL p11_duty: got %0d want 5", bus.duty); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL p11_locked: got %b want 1", bus.locked); end
        base  = dq.size();
        pbase = pe_total;
        for (int k = 0; k < 3; k++) drive_period(8, 10);
        checks++; if (dq.size() - base !== 3) begin errors++; $display("FAIL p10_dv: got %0d want 3", dq.size() - base); end
        checks++; if (bus.duty !== 4'd8) begin errors++; $display("FAIL p10_duty: got %0d want 8", bus.duty); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL p10_locked: got %b want 1", bus.locked); end
        checks++; if (pe_total - pbase !== 0) begin errors++; $display("FAIL p10_pe: got %0d want 0", pe_total - pbase); end
    endtask

    task automatic test_reset_mid;
        int base;
        @(negedge clk);
        bus.pwm_in = 1'b1;
        wait_cycles(5);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.duty !== 4'd0)   begin errors++; $display("FAIL mid_reset_duty: got %0d want 0", bus.duty); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL mid_reset_locked: got %b want 0", bus.locked); end
        checks++; if (bus.duty_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_dv: got %b want 0", bus.duty_valid); end
        hold_level(1'b0, 3);
        reset = 1'b1;
        base = dq.size();
        drive_period(3, 10);
        drive_period(3, 3);
        checks++; if (dq.size() - base !== 0) begin errors++; $display("FAIL mid_restart_no_dv: got %0d want 0", dq.size() - base); end
        hold_level(1'b0, 7);
        checks++; if (dq.size() - base !== 1) begin errors++; $display("FAIL mid_restart_dv: got %0d want 1", dq.size() - base); end
        checks++; if (bus.duty !== 4'd3) begin errors++; $display("FAIL mid_restart_duty: got %0d want 3", bus.duty); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        pe_total   = 0;
        both_cnt   = 0;
        wide_cnt   = 0;
        viol       = 0;
        dv_cyc     = 0;
        prev_dv    = 1'b0;
        reset      = 1'b0;
        bus.pwm_in = 1'b0;
        test_reset;
        test_duty(3, 3);
        test_duty(1, 1);
        test_duty(5, 5);
        test_duty(9, 9);
        test_switch;
        test_stuck;
        test_period_err;
        test_reset_mid;
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL dv_pe_overlap: got %0d cycles want 0", both_cnt); end
        checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL dv_width: got %0d wide pulses want 0", wide_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Receive-side counterpart of the 10 kHz duty-cycle PWM generator. It synchronizes an external PWM input, measures its period and high time in `clk` cycles, and reports the duty cycle in 10 % steps (0–10). It also flags off-frequency input and detects stuck-low or stuck-high lines. It sits at a chip input and feeds the control or readout logic.

## Interface
- `PERIOD_CYCLES`, 10: nominal PWM period in `clk` cycles (100 kHz clk / 10 kHz PWM).
- `PERIOD_TOL`, 1: allowed period deviation, ± cycles.
- `TIMEOUT`, 30: cycles without a rising edge before the line is declared stuck. Constraint: `TIMEOUT > PERIOD_CYCLES + PERIOD_TOL`.
- `SYNC_STAGES`, 2: synchronizer depth. Minimum is 2.
- `clk  input  1`: single clock.
- `reset  input  1`: asynchronous, active-low reset.
- `pwm_in  input  1`: asynchronous PWM input.
- `duty  output  4`: last valid duty, 0..10. Resets to 0.
- `duty_valid  output  1`: one-cycle pulse whenever `duty` is written. Resets to 0.
- `period_err  output  1`: one-cycle pulse when a measured period is out of tolerance. Resets to 0.
- `locked  output  1`: high while consecutive in-tolerance periods are being decoded. Resets to 0.

## Operation
- Signal conditioning:
  - `s` is the output of a `SYNC_STAGES` flop chain on `pwm_in`. `s_d` is `s` delayed by one cycle.
  - `rise = s & ~s_d`. `fall = ~s & s_d`.
- Measurements:
  - P is the number of cycles between consecutive `rise` strobes.
  - H is the number of cycles from a `rise` to the next `fall`.
  - All counters saturate at `TIMEOUT`. Counter width is `$clog2(TIMEOUT+1)`.
- FSM states: IDLE, HIGH, LOW, STUCK. Reset enters IDLE.
  - IDLE: on `rise`, go to HIGH and clear the counters. If there is no `rise` for `TIMEOUT` cycles, go to STUCK.
  - HIGH: on `fall`, latch H and go to LOW. On timeout, go to STUCK.
  - LOW: on `rise`, evaluate the period (below), then go to HIGH with the counters restarted. On timeout, go to STUCK.
  - STUCK: on entry, set `duty` = 10 if `s`=1 or 0 if `s`=0, pulse `duty_valid` once, and clear `locked`. On `rise`, go to HIGH. No further pulses are issued while the FSM remains in STUCK.
- Period evaluation, performed at `rise` in LOW:
  - In tolerance (|P − `PERIOD_CYCLES`| ≤ `PERIOD_TOL`):
    - `duty` = min(10, (H·10 + `PERIOD_CYCLES`/2) / `PERIOD_CYCLES`), integer division by a constant.
    - Pulse `duty_valid` and set `locked`.
  - Out of tolerance: pulse `period_err`, hold `duty`, clear `locked`.
- The first `rise` after reset or after STUCK only starts a measurement. No `duty_valid` is issued until one full period has completed.
- Simultaneous events:
  - `rise` and timeout in the same cycle: `rise` wins.
  - `duty_valid` and `period_err` are never asserted in the same cycle.
- Reset mid-operation: all outputs and state return to reset values immediately (asynchronous). Synchronizer flops reset to 0.

## Timing
- Latency from a `pwm_in` edge to the `rise`/`fall` strobe: `SYNC_STAGES`+1 cycles.
- `duty`, `duty_valid`, `period_err` and `locked` are registered. They update in the cycle after the evaluating `rise`, so latency from the `pwm_in` rising edge is `SYNC_STAGES`+2 cycles.
- The STUCK pulse occurs `TIMEOUT` cycles after the last `rise`, or after the IDLE entry, +1 register cycle.
- Steady 10-cycle input gives exactly one `duty_valid` pulse every 10 cycles, and `locked` stays high.
- The decoder never produces a pulse wider than one cycle, and no output glitches.

## Test plan
1. Hold `reset` low with `pwm_in` toggling → `duty`=0, `duty_valid`=0, `period_err`=0, `locked`=0 throughout. After release, there is no `duty_valid` before the second `rise`.
2. 30 % PWM (3 high / 7 low, period 10) → after the second rising edge, `duty`=3 with a `duty_valid` pulse every 10 cycles and `locked`=1. Repeat for 10 %, 50 % and 90 %, giving 1, 5 and 9.
3. Switch from 30 % to 70 % mid-stream → the first period completed at 70 % yields `duty`=7. There is no intermediate value and no `period_err`.
4. Hold `pwm_in` low for 40 cycles after reset → one `duty_valid` with `duty`=0 at cycle ~30 and `locked`=0. Hold it high (100 % input) → one `duty_valid` with `duty`=10. Resume 50 % PWM → `duty`=5 and relock.
5. Period 14 cycles (high 5) → `period_err` pulses each period, `duty` holds its previous value, `locked`=0. Period 11 (within tolerance) → accepted and `locked`=1. Return to period 10 → `locked`=1 and `duty` updates.
6. Assert `reset` during HIGH → outputs go to 0 asynchronously in the same cycle. After release the FSM restarts in IDLE, and the first `duty_valid` occurs only after a full new period.
